bp_be_sys_arbiter: RTL and testbench

BP_BE_SYS_ARBITER -- requirements
Module: bp_be_sys_arbiter

---
 rtl/bp_be_pkg.sv | 26 ++
 rtl/bp_be_sys_arb_hold.sv | 30 +++
 rtl/bp_be_sys_arbiter.sv | 124 ++++++++++++
 tb/tb_bp_be_sys_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Back-end shared definitions: configuration selector, dispatch packet sizing
// and the system-pipe arbiter FSM state encoding.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg,
    e_bp_unicore_cfg,
    e_bp_multicore_cfg
  } bp_params_e;

  typedef enum logic {
    e_sys_arb_idle,
    e_sys_arb_hold
  } bp_be_sys_arb_state_e;

  // Virtual address width implied by a processor configuration.
  function automatic int bp_vaddr_width(bp_params_e cfg);
    return (cfg == e_bp_multicore_cfg) ? 48 : 39;
  endfunction

  // Dispatch packet: pc + instruction + two source operands + decode flags.
  function automatic int bp_be_dispatch_pkt_width(int vaddr_width);
    return vaddr_width + 32 + 2 * 64 + 4;
  endfunction

endpackage

// File: rtl/bp_be_sys_arb_hold.sv
// Single-entry valid+payload register for the younger system request.
// Clear has priority over set so a flush can never leave a stale entry.
module bp_be_sys_arb_hold
  import bp_be_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               set_i,
  input  logic               clr_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  // Capture the held entry; drop it on clear or reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_o    <= 1'b0;
      data_o <= '0;
    end else if (clr_i) begin
      v_o    <= 1'b0;
    end else if (set_i) begin
      v_o    <= 1'b1;
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/bp_be_sys_arbiter.sv
// Two-slot to one-pipe system arbiter. Slot 0 (older) always wins; a
// conflicting slot 1 is held for one cycle and issued next, unless the
// slot-0 op serializes (held op is replayed) or a flush kills it.
// Optional feature macro: BP_BE_SYS_ARB_PERF_EN adds conflict_count_o.
module bp_be_sys_arbiter
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p     = e_bp_default_cfg,
  parameter int         payload_width_p = bp_be_dispatch_pkt_width(bp_vaddr_width(bp_params_p))
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic [1:0]                 req_v_i,
  input  logic [payload_width_p-1:0] req0_payload_i,
  input  logic [payload_width_p-1:0] req1_payload_i,
  input  logic                       serialize_i,
  output logic                       ready_o,
  output logic                       sys_v_o,
  output logic                       sys_slot_o,
  output logic [payload_width_p-1:0] sys_payload_o,
  output logic                       replay_o
`ifdef BP_BE_SYS_ARB_PERF_EN
  ,
  output logic [31:0]                conflict_count_o
`endif
);

  bp_be_sys_arb_state_e state_r, state_n;

  logic                       accept, both;
  logic                       sys_v_n, sys_slot_n, replay_n;
  logic [payload_width_p-1:0] sys_payload_n;
  logic                       hold_set, hold_clr, hold_v;
  logic [payload_width_p-1:0] hold_data;

  assign ready_o = (state_r == e_sys_arb_idle);
  assign accept  = (|req_v_i) & ready_o & ~flush_i;
  assign both    = accept & (&req_v_i);

  bp_be_sys_arb_hold #(.width_p(payload_width_p)) hold (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .set_i   (hold_set),
    .clr_i   (hold_clr),
    .data_i  (req1_payload_i),
    .v_o     (hold_v),
    .data_o  (hold_data)
  );

  // Next state and next registered outputs.
  // NOTE: every signal assigned here gets a default first, otherwise paths
  // that skip an assignment would infer latches.
  always_comb begin
    state_n       = state_r;
    sys_v_n       = 1'b0;
    sys_slot_n    = sys_slot_o;
    sys_payload_n = sys_payload_o;
    replay_n      = 1'b0;
    hold_set      = 1'b0;
    hold_clr      = 1'b0;
    if (flush_i) begin
      state_n  = e_sys_arb_idle;
      hold_clr = 1'b1;
    end else begin
      case (state_r)
        e_sys_arb_idle: begin
          if (accept) begin
            sys_v_n       = 1'b1;
            sys_slot_n    = ~req_v_i[0];
            sys_payload_n = req_v_i[0] ? req0_payload_i : req1_payload_i;
            if (both) begin
              hold_set = 1'b1;
              state_n  = e_sys_arb_hold;
            end
          end
        end
        e_sys_arb_hold: begin
          state_n  = e_sys_arb_idle;
          hold_clr = 1'b1;
          if (hold_v && serialize_i) begin
            replay_n = 1'b1;
          end else if (hold_v) begin
            sys_v_n       = 1'b1;
            sys_slot_n    = 1'b1;
            sys_payload_n = hold_data;
          end
        end
        default: state_n = e_sys_arb_idle;
      endcase
    end
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r       <= e_sys_arb_idle;
      sys_v_o       <= 1'b0;
      sys_slot_o    <= 1'b0;
      sys_payload_o <= '0;
      replay_o      <= 1'b0;
    end else begin
      state_r       <= state_n;
      sys_v_o       <= sys_v_n;
      sys_slot_o    <= sys_slot_n;
      sys_payload_o <= sys_payload_n;
      replay_o      <= replay_n;
    end
  end

`ifdef BP_BE_SYS_ARB_PERF_EN
  // Saturating count of both-slot acceptances.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      conflict_count_o <= '0;
    end else if (both && (conflict_count_o != 32'hFFFF_FFFF)) begin
      conflict_count_o <= conflict_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_sys_arbiter.sv
// Scoreboard bench for bp_be_sys_arbiter: a queue-based reference model
// predicts each presented payload or replay; a monitor compares on output.
module tb_bp_be_sys_arbiter;
  import bp_be_pkg::*;

  localparam int W = 16;

  logic         clk_i = 1'b0;
  logic         reset_i, flush_i, serialize_i;
  logic [1:0]   req_v_i;
  logic [W-1:0] req0_payload_i, req1_payload_i;
  logic         ready_o, sys_v_o, sys_slot_o, replay_o;
  logic [W-1:0] sys_payload_o;
`ifdef BP_BE_SYS_ARB_PERF_EN
  logic [31:0]  conflict_count_o;
`endif

  bp_be_sys_arbiter #(.bp_params_p(e_bp_default_cfg), .payload_width_p(W)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .req_v_i        (req_v_i),
    .req0_payload_i (req0_payload_i),
    .req1_payload_i (req1_payload_i),
    .serialize_i    (serialize_i),
    .ready_o        (ready_o),
    .sys_v_o        (sys_v_o),
    .sys_slot_o     (sys_slot_o),
    .sys_payload_o  (sys_payload_o),
    .replay_o       (replay_o)
`ifdef BP_BE_SYS_ARB_PERF_EN
    ,
    .conflict_count_o (conflict_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           replay;
    bit           slot;
    logic [W-1:0] payload;
  } ev_t;

  ev_t          exp_q[$];
  logic [W-1:0] pending_q[$];   // younger request waiting for the pipe
  int           conflicts = 0;
  logic [W-1:0] last_payload = '0;
  bit           last_slot = 1'b0;
  int           tests = 0;
  int           fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: check readiness, drive, and predict the next edge.
  task automatic drive(input logic [1:0] req, input logic [W-1:0] p0, input logic [W-1:0] p1,
                       input logic flush, input logic ser);
    ev_t e;
    @(negedge clk_i);
    check("ready", {31'd0, ready_o}, {31'd0, pending_q.size() == 0});
    req_v_i = req; req0_payload_i = p0; req1_payload_i = p1;
    flush_i = flush; serialize_i = ser;
    if (flush) begin
      pending_q.delete();
    end else if (pending_q.size() != 0) begin
      e.payload = pending_q.pop_front();
      e.slot    = 1'b1;
      e.replay  = ser;
      exp_q.push_back(e);
    end else if (req != 2'b00) begin
      e.replay  = 1'b0;
      e.slot    = !req[0];
      e.payload = req[0] ? p0 : p1;
      exp_q.push_back(e);
      if (req == 2'b11) begin
        pending_q.push_back(p1);
        conflicts++;
      end
    end
  endtask

  // Monitor: compare every presented payload or replay against the queue.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk_i);
      #1;
      check("no_v_and_replay", {31'd0, sys_v_o & replay_o}, 32'd0);
      if (sys_v_o || replay_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {30'd0, sys_v_o, replay_o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("replay", {31'd0, replay_o}, {31'd0, e.replay});
          if (!e.replay) begin
            check("slot", {31'd0, sys_slot_o}, {31'd0, e.slot});
            check("payload", {16'd0, sys_payload_o}, {16'd0, e.payload});
            last_payload = e.payload;
            last_slot    = e.slot;
          end
        end
      end else begin
        check("hold_payload", {16'd0, sys_payload_o}, {16'd0, last_payload});
        check("hold_slot", {31'd0, sys_slot_o}, {31'd0, last_slot});
      end
    end
  end

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; serialize_i = 1'b0; req_v_i = 2'b00;
    req0_payload_i = '0; req1_payload_i = '0;
    #2;
    check("rst_sys_v", {31'd0, sys_v_o}, 32'd0);
    check("rst_slot", {31'd0, sys_slot_o}, 32'd0);
    check("rst_payload", {16'd0, sys_payload_o}, 32'd0);
    check("rst_replay", {31'd0, replay_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    @(negedge clk_i); @(negedge clk_i);
    reset_i = 1'b0;

    // Slot 0 alone, then both slots, then idle.
    drive(2'b01, 16'h00A1, 16'h0000, 1'b0, 1'b0);
    drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drive(2'b11, 16'h00A1, 16'h00B2, 1'b0, 1'b0);
    drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
`ifdef BP_BE_SYS_ARB_PERF_EN
    check("conflict_one", conflict_count_o, 32'd1);
`endif
    // Slot 1 alone.
    drive(2'b10, 16'h0011, 16'h00C3, 1'b0, 1'b0);
    // Both, then serialize in HOLD -> replay.
    drive(2'b11, 16'h0021, 16'h0022, 1'b0, 1'b0);
    drive(2'b01, 16'h0099, 16'h0000, 1'b0, 1'b1);
    drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    // Both, then flush in HOLD -> nothing, ready returns.
    drive(2'b11, 16'h0031, 16'h0032, 1'b0, 1'b0);
    drive(2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1);
    drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    // Flush together with a both-slot request -> nothing presented.
    drive(2'b11, 16'h0041, 16'h0042, 1'b1, 1'b0);
    drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Reset mid-cycle while in HOLD drops the held entry silently.
    drive(2'b11, 16'h0051, 16'h0052, 1'b0, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b1;
    pending_q.delete();
    last_payload = '0;
    last_slot    = 1'b0;
    #1;
    check("rst_hold_sys_v", {31'd0, sys_v_o}, 32'd0);
    check("rst_hold_replay", {31'd0, replay_o}, 32'd0);
    check("rst_hold_ready", {31'd0, ready_o}, 32'd1);
    req_v_i = 2'b00;
    @(negedge clk_i);
    reset_i = 1'b0;
    conflicts = 0;
`ifdef BP_BE_SYS_ARB_PERF_EN
    check("conflict_rst", conflict_count_o, 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      drive(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 3; i++) drive(2'b00, '0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    check("drained", exp_q.size(), 32'd0);
`ifdef BP_BE_SYS_ARB_PERF_EN
    check("conflict_count", conflict_count_o, conflicts);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
